// File: rtl/seg_scan_ctrl.sv
// Round-robin scan controller sharing one active-low 7-segment bus across four common-anode digits.
// Define SCAN_BLANK_EN to insert BLANK_CYC all-off cycles between digits (anti-ghosting).
module seg_scan_ctrl #(
   parameter int unsigned SCAN_DIV = 100000
`ifdef SCAN_BLANK_EN
   ,
   parameter int unsigned BLANK_CYC = 4
`endif
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        EN,
   input  logic [15:0] DIGITS,
   input  logic [3:0]  VALID,
   output logic        a,
   output logic        b,
   output logic        c,
   output logic        d,
   output logic        e,
   output logic        f,
   output logic        g,
   output logic [3:0]  AN
);

   localparam int unsigned PcntW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam logic [PcntW-1:0] PcntLast = PcntW'(SCAN_DIV - 1);
   localparam logic [PcntW-1:0] PcntOne  = PcntW'(1);

   localparam logic [6:0] SegOff  = 7'b1111111;
   localparam logic [6:0] SegDash = 7'b1111110;
   localparam logic [3:0] AnOff   = 4'b1111;

`ifdef SCAN_BLANK_EN
   localparam logic [7:0] BcntLast = 8'(BLANK_CYC - 1);

   typedef enum logic [1:0] {StIdle, StShow, StBlank} state_e;
`else
   typedef enum logic [1:0] {StIdle, StShow} state_e;
`endif

   state_e           state_q;
   logic [1:0]       ptr_q;
   logic [PcntW-1:0] pcnt_q;
   logic [6:0]       seg_q;
   logic [3:0]       an_q;
`ifdef SCAN_BLANK_EN
   logic [7:0]       bcnt_q;
`endif

   logic [1:0] ptr_nxt;
   logic [3:0] dig_nxt;
   logic       vld_nxt;
   logic [3:0] an_nxt;
   logic [3:0] dig_first;

   // Segment pattern {a,b,c,d,e,f,g}, active-low; invalid or non-decimal shows a dash.
   function automatic logic [6:0] decode(input logic [3:0] val, input logic vld);
      logic [6:0] seg;
      seg = SegDash;
      if (vld) begin
         case (val)
            4'd0:    seg = 7'b0000001;
            4'd1:    seg = 7'b1001111;
            4'd2:    seg = 7'b0010010;
            4'd3:    seg = 7'b0000110;
            4'd4:    seg = 7'b1001100;
            4'd5:    seg = 7'b0100100;
            4'd6:    seg = 7'b1100000;
            4'd7:    seg = 7'b0001111;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0000100;
            default: seg = SegDash;
         endcase
      end
      return seg;
   endfunction

   always_comb begin
      ptr_nxt   = ptr_q + 2'd1;
      dig_nxt   = DIGITS[{ptr_nxt, 2'b00} +: 4];
      vld_nxt   = VALID[ptr_nxt];
      an_nxt    = ~(4'b0001 << ptr_nxt);
      dig_first = DIGITS[3:0];
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= StIdle;
         ptr_q   <= 2'd0;
         pcnt_q  <= '0;
         seg_q   <= SegOff;
         an_q    <= AnOff;
`ifdef SCAN_BLANK_EN
         bcnt_q  <= 8'd0;
`endif
      end else if (!EN) begin
         state_q <= StIdle;
         ptr_q   <= 2'd0;
         pcnt_q  <= '0;
         seg_q   <= SegOff;
         an_q    <= AnOff;
`ifdef SCAN_BLANK_EN
         bcnt_q  <= 8'd0;
`endif
      end else begin
         case (state_q)
            StIdle: begin
               state_q <= StShow;
               ptr_q   <= 2'd0;
               pcnt_q  <= '0;
               an_q    <= 4'b1110;
               seg_q   <= decode(dig_first, VALID[0]);
            end
            StShow: begin
               if (pcnt_q == PcntLast) begin
                  pcnt_q <= '0;
`ifdef SCAN_BLANK_EN
                  state_q <= StBlank;
                  bcnt_q  <= 8'd0;
                  an_q    <= AnOff;
                  seg_q   <= SegOff;
`else
                  // Back-to-back switch: next digit is sampled and shown on this edge.
                  ptr_q <= ptr_nxt;
                  an_q  <= an_nxt;
                  seg_q <= decode(dig_nxt, vld_nxt);
`endif
               end else begin
                  pcnt_q <= pcnt_q + PcntOne;
               end
            end
`ifdef SCAN_BLANK_EN
            StBlank: begin
               if (bcnt_q == BcntLast) begin
                  state_q <= StShow;
                  ptr_q   <= ptr_nxt;
                  pcnt_q  <= '0;
                  an_q    <= an_nxt;
                  seg_q   <= decode(dig_nxt, vld_nxt);
               end else begin
                  bcnt_q <= bcnt_q + 8'd1;
               end
            end
`endif
            default: begin
               state_q <= StIdle;
               ptr_q   <= 2'd0;
               pcnt_q  <= '0;
               seg_q   <= SegOff;
               an_q    <= AnOff;
            end
         endcase
      end
   end

   assign {a, b, c, d, e, f, g} = seg_q;
   assign AN = an_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl (SCAN_DIV=4, BLANK_CYC=2); compile with SCAN_BLANK_EN for blanking.
module tb_seg_scan_ctrl;

   localparam int unsigned ScanDiv = 4;
`ifdef SCAN_BLANK_EN
   localparam int unsigned Gap = 2;
`else
   localparam int unsigned Gap = 0;
`endif

   localparam logic [6:0] S0 = 7'b0000001;
   localparam logic [6:0] S1 = 7'b1001111;
   localparam logic [6:0] S2 = 7'b0010010;
   localparam logic [6:0] S3 = 7'b0000110;
   localparam logic [6:0] S5 = 7'b0100100;
   localparam logic [6:0] S9 = 7'b0000100;
   localparam logic [6:0] SD = 7'b1111110;
   localparam logic [10:0] Off = 11'h7FF;

   logic        CLK = 1'b0;
   logic        RESET;
   logic        EN;
   logic [15:0] DIGITS;
   logic [3:0]  VALID;
   logic        a, b, c, d, e, f, g;
   logic [3:0]  AN;

   int n_checks = 0;
   int n_pass = 0;

   always #5 CLK = ~CLK;

   seg_scan_ctrl #(
      .SCAN_DIV (ScanDiv)
`ifdef SCAN_BLANK_EN
      ,
      .BLANK_CYC(2)
`endif
   ) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .EN    (EN),
      .DIGITS(DIGITS),
      .VALID (VALID),
      .a     (a),
      .b     (b),
      .c     (c),
      .d     (d),
      .e     (e),
      .f     (f),
      .g     (g),
      .AN    (AN)
   );

   task automatic check_eq(input string tag, input logic [10:0] obs, input logic [10:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: AN/seg got %b_%b, expected %b_%b", tag, obs[10:7], obs[6:0],
                    exp[10:7], exp[6:0]);
   endtask

   // Check one full dwell of a digit, one comparison per falling edge.
   task automatic show(input string tag, input logic [3:0] an, input logic [6:0] seg);
      for (int i = 0; i < int'(ScanDiv); i++) begin
         @(negedge CLK);
         check_eq(tag, {AN, a, b, c, d, e, f, g}, {an, seg});
      end
   endtask

   task automatic gap(input string tag);
      for (int i = 0; i < int'(Gap); i++) begin
         @(negedge CLK);
         check_eq(tag, {AN, a, b, c, d, e, f, g}, Off);
      end
   endtask

   task automatic one(input string tag, input logic [10:0] exp);
      @(negedge CLK);
      check_eq(tag, {AN, a, b, c, d, e, f, g}, exp);
   endtask

   initial begin
      RESET = 1'b1;
      EN = 1'b0;
      DIGITS = 16'h0000;
      VALID = 4'h0;
      one("reset", Off);
      RESET = 1'b0;
      for (int i = 0; i < 3; i++) one("idle_en0", Off);

      // Scan order, full frame then wrap to digit 0
      DIGITS = 16'h3210;
      VALID = 4'b1111;
      EN = 1'b1;
      show("scan_d0", 4'b1110, S0); gap("scan_blank0");
      show("scan_d1", 4'b1101, S1); gap("scan_blank1");
      show("scan_d2", 4'b1011, S2); gap("scan_blank2");
      show("scan_d3", 4'b0111, S3); gap("scan_blank3");
      show("scan_wrap_d0", 4'b1110, S0);
      EN = 1'b0;
      one("dis_a", Off);

      // Invalid and non-decimal digits show a dash
      DIGITS = 16'hF7A5;
      VALID = 4'b1011;
      EN = 1'b1;
      show("inv_d0", 4'b1110, S5); gap("inv_blank");
      show("inv_d1", 4'b1101, SD); gap("inv_blank");
      show("inv_d2", 4'b1011, SD); gap("inv_blank");
      show("inv_d3", 4'b0111, SD); gap("inv_blank");
      EN = 1'b0;
      one("dis_b", Off);

      // Snapshot: digit 0 changes one cycle into its dwell
      DIGITS = 16'h0002;
      VALID = 4'b1111;
      EN = 1'b1;
      one("snap_first", {4'b1110, S2});
      DIGITS = 16'h0009;
      for (int i = 1; i < int'(ScanDiv); i++) one("snap_hold", {4'b1110, S2});
      gap("snap_blank");
      show("snap_d1", 4'b1101, S0); gap("snap_blank");
      show("snap_d2", 4'b1011, S0); gap("snap_blank");
      show("snap_d3", 4'b0111, S0); gap("snap_blank");
      show("snap_new", 4'b1110, S9); gap("snap_blank");

      // Disable during digit 2, then restart at digit 0
      show("pre_dis_d1", 4'b1101, S0); gap("pre_dis_blank");
      one("pre_dis_d2", {4'b1011, S0});
      EN = 1'b0;
      one("dis_off", Off);
      one("dis_hold", Off);
      EN = 1'b1;
      show("restart_d0", 4'b1110, S9); gap("restart_blank");
      show("restart_d1", 4'b1101, S0); gap("restart_blank");
      show("restart_d2", 4'b1011, S0);

      // Reset mid-operation: during blanking if present, otherwise during digit 3
`ifdef SCAN_BLANK_EN
      one("pre_rst_blank", Off);
`else
      one("pre_rst_d3", {4'b0111, S0});
`endif
      RESET = 1'b1;
      one("rst_mid", Off);
      RESET = 1'b0;
      show("post_rst_d0", 4'b1110, S9); gap("post_rst_blank");
      show("post_rst_d1", 4'b1101, S0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: bench did not finish, got running expected done");
      $fatal(1);
   end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexing scan controller that shares one active-low 7-segment bus (a..g) between four digit sources on a 4-digit common-anode display. Each digit's 4-bit value is snapshotted and decoded, then its anode is driven for a fixed dwell time before the controller moves to the next digit, round-robin. It sits between counter/FSM blocks such as the 3-bit counter with 7-segment driver (which supply digit values) and the board display pins.

## Interface
- SCAN_DIV, 100000: dwell time per digit in CLK cycles (1 kHz per digit at 100 MHz); legal range 2..2^20.
- BLANK_CYC, 4: blanking cycles between digits; legal range 1..255; used only when SCAN_BLANK_EN is defined.

- CLK  input  1  system clock; all state updates on the rising edge.
- RESET  input  1  synchronous, active-high reset; dominates all other inputs.
- EN  input  1  scan enable; 0 forces display off.
- DIGITS  input  16  digit values; DIGITS[4k+3:4k] belongs to digit k.
- VALID  input  4  VALID[k]=1 means digit k holds a real value.
- a, b, c, d, e, f, g  output  1 each  segment drives, active-low, registered.
- AN  output  4  anode selects, active-low, one-hot-low or all 1, registered.

## Operation
- Reset values: AN=4'b1111, {a..g}=7'b1111111, digit pointer PTR=0, prescaler PCNT=0, blank counter BCNT=0, state IDLE.
- States: IDLE, SHOW, BLANK (BLANK exists only with SCAN_BLANK_EN).
- IDLE: outputs off (AN=1111, segs=1111111). EN=1 at an edge -> SHOW with PTR=0, PCNT=0, AN=1110, segs=decode(DIGITS[3:0], VALID[0]).
- SHOW: AN[PTR]=0, all other anodes 1; PCNT increments each cycle. On the edge where PCNT==SCAN_DIV-1:
  - With macro: -> BLANK; AN=1111, segs=1111111, BCNT=0.
  - Without macro: PTR=PTR+1 (mod 4), PCNT=0, load the new digit's decode and anode on that same edge.
- BLANK: BCNT increments. On the edge where BCNT==BLANK_CYC-1: -> SHOW, PTR=PTR+1 (mod 4), PCNT=0, load the decode and anode.
- Snapshot rule: DIGITS/VALID are sampled only on the edge that loads a digit. Changes during a dwell do not affect the displayed pattern until that digit's next turn.
- Decode (abcdefg, active-low):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=1100000, 7=0001111, 8=0000000, 9=0000100
  - Values 10..15, or VALID[k]=0: dash 1111110.
- EN=0 in any state: next edge -> IDLE, outputs off, PTR=0, PCNT=0. Re-enabling always restarts at digit 0.
- RESET high in any state: next edge restores all reset values, even mid-dwell or mid-blank.
- PTR wraps 3 -> 0. PCNT is wide enough for SCAN_DIV-1 and never exceeds it.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- EN rise to first anode low: 1 edge.
- Dwell: exactly SCAN_DIV cycles of AN low per digit.
- Frame period: 4*SCAN_DIV cycles without the macro; 4*(SCAN_DIV+BLANK_CYC) with it.
- Never more than one AN bit low. During blanking, AN=1111 and segs=1111111 for exactly BLANK_CYC cycles.
- EN fall to display off: 1 edge.

## Configuration
- SCAN_BLANK_EN defined: BLANK state is compiled in and every digit change passes through BLANK_CYC all-off cycles (anti-ghosting).
- SCAN_BLANK_EN undefined: no BLANK state, BCNT and BLANK_CYC are unused, and digits switch back-to-back on one edge.

## Test plan
Bench parameters: SCAN_DIV=4, BLANK_CYC=2, CLOCK_PERIOD=10 ns. Check outputs at falling edges.
- Reset: RESET=1, EN=0 for 1 cycle -> AN=1111, segs=1111111. Keep EN=0 for 3 cycles -> outputs unchanged.
- Scan order: DIGITS=16'h3210, VALID=1111, EN=1 -> digit 0 (AN=1110, 0000001) for 4 cycles, then digit 1 (1101, 1001111), digit 2 (1011, 0010010), digit 3 (0111, 0000110), then back to digit 0.
  - With macro: 2 cycles of AN=1111 between digits; frame is 24 cycles.
  - Without macro: frame is 16 cycles.
- Invalid input: DIGITS=16'hF7A5, VALID=1011 -> digit 0 shows 0100100 (5), digit 1 shows 1111110 (value 10), digit 2 shows 1111110 (VALID[2]=0), digit 3 shows 1111110 (value 15).
- Snapshot: change DIGITS[3:0] from 2 to 9 one cycle into digit 0's dwell -> digit 0 stays 0010010 for its full dwell and shows 0000100 on the next frame.
- Disable/restart: drop EN during digit 2 -> off on the next edge. Reassert EN -> scan restarts at AN=1110.
- Reset mid-operation: RESET=1 for one edge during BLANK (macro build) or during SHOW of digit 3 -> reset values on that edge. With EN=1 after release, scanning resumes at digit 0.
